// File: rtl/reg_file_bank.sv
// reg_file_bank: file-register responder for the execute-stage write command.
// Latches the file address, resolves INDF through FSR, holds TMR0, STATUS,
// FSR, the port latches and the general-purpose RAM, and returns
// combinational read data for the effective address.
// Build option: define BANKED_GPR_EN for four 16-byte banks at 0x10-0x1F
// selected by FSR[6:5]. Without it, 0x08-0x1F is a single 24-byte array.
module reg_file_bank #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned TMR0_INHIBIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            writeCommand,
  input  logic [DATA_WIDTH-1:0] gprWriteDataIn,
  input  logic [DATA_WIDTH-1:0] statusWriteDataIn,
  input  logic                  tmr0IncEn,
  input  logic [DATA_WIDTH-1:0] pclIn,
  input  logic [DATA_WIDTH-1:0] portAIn,
  input  logic [DATA_WIDTH-1:0] portBIn,
  input  logic [DATA_WIDTH-1:0] portCIn,
  output logic [DATA_WIDTH-1:0] gprReadDataOut,
  output logic [DATA_WIDTH-1:0] gprStatusOut,
  output logic [DATA_WIDTH-1:0] fsrOut,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  pclWriteEn,
  output logic [DATA_WIDTH-1:0] pclDataOut,
  output logic [DATA_WIDTH-1:0] portAOut,
  output logic [DATA_WIDTH-1:0] portBOut,
  output logic [DATA_WIDTH-1:0] portCOut
);

  // File map
  localparam logic [ADDR_WIDTH-1:0] AIndf   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ATmr0   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] APcl    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] AStatus = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] AFsr    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] APortA  = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] APortB  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] APortC  = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] AGprLo  = ADDR_WIDTH'(8);

  localparam logic [DATA_WIDTH-1:0] StatusRst = DATA_WIDTH'(8'h18);

  localparam int unsigned InhW = (TMR0_INHIBIT > 0) ? $clog2(TMR0_INHIBIT + 1) : 1;
  localparam logic [InhW-1:0] InhLoad = InhW'(TMR0_INHIBIT);

`ifdef BANKED_GPR_EN
  // 8 shared bytes followed by 4 banks of 16
  localparam int unsigned GprDepth = 72;
  localparam int unsigned GprIdxW  = 7;
  localparam logic [DATA_WIDTH-1:0] FsrWrMask  = DATA_WIDTH'(8'h7F);
  localparam logic [DATA_WIDTH-1:0] FsrRdForce = DATA_WIDTH'(8'h80);
`else
  localparam int unsigned GprDepth = 24;
  localparam int unsigned GprIdxW  = 5;
  localparam logic [DATA_WIDTH-1:0] FsrWrMask  = DATA_WIDTH'(8'h1F);
  localparam logic [DATA_WIDTH-1:0] FsrRdForce = DATA_WIDTH'(8'hE0);
`endif

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_fsr;
  logic [DATA_WIDTH-1:0] r_status;
  logic [DATA_WIDTH-1:0] r_tmr0;
  logic [InhW-1:0]       r_inh;
  logic [DATA_WIDTH-1:0] r_port_a;
  logic [DATA_WIDTH-1:0] r_port_b;
  logic [DATA_WIDTH-1:0] r_port_c;
  logic [DATA_WIDTH-1:0] r_gpr [GprDepth];

  logic [ADDR_WIDTH-1:0] w_eff;
  logic [GprIdxW-1:0]    w_gpr_idx;
  logic                  w_wr;
  logic                  w_wr_tmr0;
  logic                  w_wr_pcl;
  logic                  w_wr_status;
  logic                  w_wr_fsr;
  logic                  w_wr_gpr;
  logic [DATA_WIDTH-1:0] w_status_d;
  logic [DATA_WIDTH-1:0] w_fsr_rd;

  // Effective address and GPR array index
  always_comb begin
    w_eff = (r_addr == AIndf) ? r_fsr[ADDR_WIDTH-1:0] : r_addr;
`ifdef BANKED_GPR_EN
    if (w_eff[4]) begin
      w_gpr_idx = 7'd8 + {1'b0, r_fsr[6:5], w_eff[3:0]};
    end else begin
      w_gpr_idx = 7'(w_eff) - 7'd8;
    end
`else
    w_gpr_idx = GprIdxW'(w_eff - AGprLo);
`endif
  end

  // Write decode; an indirect access that lands on INDF itself is a NOP
  always_comb begin
    w_wr        = writeCommand[1] && (w_eff != AIndf);
    w_wr_tmr0   = w_wr && (w_eff == ATmr0);
    w_wr_pcl    = w_wr && (w_eff == APcl);
    w_wr_status = w_wr && (w_eff == AStatus);
    w_wr_fsr    = w_wr && (w_eff == AFsr);
    w_wr_gpr    = w_wr && (w_eff >= AGprLo);
  end

  // STATUS next value; TO/PD (bits 4:3) are never written here
  always_comb begin
    w_status_d = r_status;
    if (w_wr_status) begin
      w_status_d[7:5] = gprWriteDataIn[7:5];
      w_status_d[2:0] = writeCommand[0] ? statusWriteDataIn[2:0] : gprWriteDataIn[2:0];
    end else if (writeCommand[0]) begin
      w_status_d[7:5] = statusWriteDataIn[7:5];
      w_status_d[2:0] = statusWriteDataIn[2:0];
    end
  end

  // Address latch, FSR, STATUS and port latches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_fsr    <= '0;
      r_status <= StatusRst;
      r_port_a <= '0;
      r_port_b <= '0;
      r_port_c <= '0;
    end else begin
      if (writeCommand[2]) r_addr <= gprWriteDataIn[ADDR_WIDTH-1:0];
      if (w_wr_fsr) r_fsr <= gprWriteDataIn & FsrWrMask;
      r_status <= w_status_d;
      if (w_wr && (w_eff == APortA)) r_port_a <= gprWriteDataIn;
      if (w_wr && (w_eff == APortB)) r_port_b <= gprWriteDataIn;
      if (w_wr && (w_eff == APortC)) r_port_c <= gprWriteDataIn;
    end
  end

  // TMR0: a write wins over a same-cycle pulse and restarts the inhibit window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr0 <= '0;
      r_inh  <= '0;
    end else if (w_wr_tmr0) begin
      r_tmr0 <= gprWriteDataIn;
      r_inh  <= InhLoad;
    end else if (tmr0IncEn) begin
      if (r_inh == '0) begin
        r_tmr0 <= r_tmr0 + DATA_WIDTH'(1);
      end else begin
        r_inh <= r_inh - InhW'(1);
      end
    end
  end

  // General-purpose RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < GprDepth; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_wr_gpr) begin
      r_gpr[w_gpr_idx] <= gprWriteDataIn;
    end
  end

  // Combinational read of the effective address
  always_comb begin
    w_fsr_rd = r_fsr | FsrRdForce;
    unique case (w_eff)
      AIndf:   gprReadDataOut = '0;
      ATmr0:   gprReadDataOut = r_tmr0;
      APcl:    gprReadDataOut = pclIn;
      AStatus: gprReadDataOut = r_status;
      AFsr:    gprReadDataOut = w_fsr_rd;
      APortA:  gprReadDataOut = portAIn;
      APortB:  gprReadDataOut = portBIn;
      APortC:  gprReadDataOut = portCIn;
      default: gprReadDataOut = r_gpr[w_gpr_idx];
    endcase
  end

  // PCL has no storage here; the write is forwarded as a strobe
  always_comb begin
    pclWriteEn = !rst && w_wr_pcl;
    pclDataOut = pclWriteEn ? gprWriteDataIn : '0;
  end

  assign gprStatusOut = r_status;
  assign fsrOut       = w_fsr_rd;
  assign addrOut      = r_addr;
  assign portAOut     = r_port_a;
  assign portBOut     = r_port_b;
  assign portCOut     = r_port_c;

endmodule

// File: tb/tb_reg_file_bank.sv
// Bench for reg_file_bank: directed test-plan sequences followed by random
// commands, all checked against a behavioural model of the file map.
// Honours BANKED_GPR_EN when the design is built with it.
module tb_reg_file_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] writeCommand;
  logic [7:0] gprWriteDataIn, statusWriteDataIn;
  logic       tmr0IncEn;
  logic [7:0] pclIn, portAIn, portBIn, portCIn;
  logic [7:0] gprReadDataOut, gprStatusOut, fsrOut;
  logic [4:0] addrOut;
  logic       pclWriteEn;
  logic [7:0] pclDataOut, portAOut, portBOut, portCOut;

  always #5 clk = ~clk;

  reg_file_bank #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (5),
    .TMR0_INHIBIT(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .writeCommand     (writeCommand),
    .gprWriteDataIn   (gprWriteDataIn),
    .statusWriteDataIn(statusWriteDataIn),
    .tmr0IncEn        (tmr0IncEn),
    .pclIn            (pclIn),
    .portAIn          (portAIn),
    .portBIn          (portBIn),
    .portCIn          (portCIn),
    .gprReadDataOut   (gprReadDataOut),
    .gprStatusOut     (gprStatusOut),
    .fsrOut           (fsrOut),
    .addrOut          (addrOut),
    .pclWriteEn       (pclWriteEn),
    .pclDataOut       (pclDataOut),
    .portAOut         (portAOut),
    .portBOut         (portBOut),
    .portCOut         (portCOut)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
`ifdef BANKED_GPR_EN
  localparam bit Banked = 1'b1;
  localparam logic [7:0] FsrKeep = 8'h7F;
  localparam logic [7:0] FsrSet  = 8'h80;
`else
  localparam bit Banked = 1'b0;
  localparam logic [7:0] FsrKeep = 8'h1F;
  localparam logic [7:0] FsrSet  = 8'hE0;
`endif

  logic [7:0] m_ram [4][32];  // [bank][address]
  logic [4:0] m_addr;
  logic [7:0] m_fsr;          // value as read back
  logic [7:0] m_status, m_tmr, m_pa, m_pb, m_pc;
  int         m_inh;

  task automatic model_reset();
    m_addr = 0; m_fsr = FsrSet; m_status = 8'h18; m_tmr = 0; m_inh = 0;
    m_pa = 0; m_pb = 0; m_pc = 0;
    for (int b = 0; b < 4; b++) for (int a = 0; a < 32; a++) m_ram[b][a] = 8'h00;
  endtask

  function automatic logic [4:0] m_eff();
    return (m_addr == 0) ? m_fsr[4:0] : m_addr;
  endfunction

  function automatic int m_bank(input logic [4:0] a);
    return (Banked && a >= 16) ? int'(m_fsr[6:5]) : 0;
  endfunction

  function automatic logic [7:0] m_read();
    logic [4:0] a = m_eff();
    case (a)
      0: return 8'h00;
      1: return m_tmr;
      2: return pclIn;
      3: return m_status;
      4: return m_fsr;
      5: return portAIn;
      6: return portBIn;
      7: return portCIn;
      default: return m_ram[m_bank(a)][a];
    endcase
  endfunction

  task automatic model_step();
    logic [4:0] a;
    int         bk;
    bit         tmr_wr, st_wr;
    if (rst) begin
      model_reset();
      return;
    end
    a = m_eff();
    bk = m_bank(a);
    tmr_wr = 0;
    st_wr = 0;
    if (writeCommand[1] && a != 0) begin
      case (a)
        1: begin m_tmr = gprWriteDataIn; m_inh = 2; tmr_wr = 1; end
        2: ;
        3: begin
          m_status = {gprWriteDataIn[7:5], m_status[4:3],
                      writeCommand[0] ? statusWriteDataIn[2:0] : gprWriteDataIn[2:0]};
          st_wr = 1;
        end
        4: m_fsr = (gprWriteDataIn & FsrKeep) | FsrSet;
        5: m_pa = gprWriteDataIn;
        6: m_pb = gprWriteDataIn;
        7: m_pc = gprWriteDataIn;
        default: m_ram[bk][a] = gprWriteDataIn;
      endcase
    end
    if (writeCommand[0] && !st_wr)
      m_status = {statusWriteDataIn[7:5], m_status[4:3], statusWriteDataIn[2:0]};
    if (tmr0IncEn && !tmr_wr) begin
      if (m_inh == 0) m_tmr = m_tmr + 8'd1;
      else m_inh--;
    end
    if (writeCommand[2]) m_addr = gprWriteDataIn[4:0];
  endtask

  // ---------------- stimulus helpers ----------------
  // Apply inputs mid-cycle and compare every output against the model
  task automatic drive(input logic r, input logic [2:0] cmd, input logic [7:0] g,
                       input logic [7:0] s, input logic inc);
    logic exp_en;
    @(negedge clk);
    rst = r; writeCommand = cmd; gprWriteDataIn = g; statusWriteDataIn = s; tmr0IncEn = inc;
    pclIn = 8'($urandom); portAIn = 8'($urandom); portBIn = 8'($urandom);
    portCIn = 8'($urandom);
    #1;
    exp_en = !r && cmd[1] && (m_eff() == 5'd2);
    check_value("rd", gprReadDataOut, m_read());
    check_value("pcl_en", pclWriteEn, exp_en);
    check_value("pcl_data", pclDataOut, exp_en ? g : 8'h00);
    check_value("status", gprStatusOut, m_status);
    check_value("fsr", fsrOut, m_fsr);
    check_value("addr", addrOut, m_addr);
    check_value("porta", portAOut, m_pa);
    check_value("portb", portBOut, m_pb);
    check_value("portc", portCOut, m_pc);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input logic [2:0] cmd, input logic [7:0] g);
    drive(1'b0, cmd, g, 8'h00, 1'b0);
    step();
  endtask

  // Idle cycle with an extra check of the read port against a fixed value
  task automatic idle_check(input string tag, input logic [7:0] exp);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    check_value(tag, gprReadDataOut, exp);
    step();
  endtask

  logic [7:0] tmr_seq [4];

  initial begin
    model_reset();
    rst = 1'b1; writeCommand = 0; gprWriteDataIn = 0; statusWriteDataIn = 0; tmr0IncEn = 0;
    pclIn = 0; portAIn = 0; portBIn = 0; portCIn = 0;

    // Reset with live commands: they must be ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b111, 8'h0A, 8'hFF, 1'b1);
      check_value("rst_pcl_en", pclWriteEn, 1'b0);
      step();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    check_value("rst_status", gprStatusOut, 8'h18);
    check_value("rst_fsr", fsrOut, Banked ? 8'h80 : 8'hE0);
    check_value("rst_addr", addrOut, 5'h00);
    check_value("rst_pcl_en0", pclWriteEn, 1'b0);
    step();
    for (int a = 8; a < 32; a++) begin
      cyc(3'b100, 8'(a));
      idle_check("rst_gpr", 8'h00);
    end

    // Direct write then read
    cyc(3'b100, 8'h0A);
    cyc(3'b010, 8'h5C);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    check_value("gpr_0a", gprReadDataOut, 8'h5C);
    check_value("addr_0a", addrOut, 5'h0A);
    step();

    // Indirect write through INDF
    cyc(3'b100, 8'h04); cyc(3'b010, 8'h0A);
    cyc(3'b100, 8'h00); cyc(3'b010, 8'h77);
    cyc(3'b100, 8'h0A);
    idle_check("indf_wr", 8'h77);
    // INDF pointing at itself
    cyc(3'b100, 8'h04); cyc(3'b010, 8'h00);
    cyc(3'b100, 8'h00);
    idle_check("indf_self_rd", 8'h00);
    cyc(3'b010, 8'h55);
    idle_check("indf_self_wr", 8'h00);
    cyc(3'b100, 8'h0A);
    idle_check("indf_self_keep", 8'h77);

    // STATUS data + status write in one cycle
    cyc(3'b100, 8'h03);
    drive(1'b0, 3'b011, 8'hE0, 8'h05, 1'b0);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    check_value("status_merge", gprStatusOut, 8'hFD);
    step();
    // Status-only write keeps TO/PD
    drive(1'b0, 3'b001, 8'h00, 8'h00, 1'b0);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    check_value("status_only", gprStatusOut, 8'h18);
    step();

    // TMR0 inhibit and wrap
    cyc(3'b100, 8'h01);
    cyc(3'b010, 8'hFE);
    idle_check("tmr_load", 8'hFE);
    tmr_seq[0] = 8'hFE; tmr_seq[1] = 8'hFE; tmr_seq[2] = 8'hFF; tmr_seq[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      step();
      idle_check("tmr_pulse", tmr_seq[i]);
    end
    // Write and pulse together: write wins, inhibit restarts
    drive(1'b0, 3'b010, 8'h10, 8'h00, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      step();
    end
    idle_check("tmr_wr_wins", 8'h11);

    // PCL write strobe
    cyc(3'b100, 8'h02);
    drive(1'b0, 3'b010, 8'h40, 8'h00, 1'b0);
    check_value("pcl_strobe", pclWriteEn, 1'b1);
    check_value("pcl_value", pclDataOut, 8'h40);
    step();
    drive(1'b0, 3'b000, 8'h40, 8'h00, 1'b0);
    check_value("pcl_strobe_off", pclWriteEn, 1'b0);
    check_value("pcl_value_off", pclDataOut, 8'h00);
    step();

`ifdef BANKED_GPR_EN
    cyc(3'b100, 8'h04); cyc(3'b010, 8'h20);
    cyc(3'b100, 8'h10); cyc(3'b010, 8'h11);
    idle_check("bank1_10", 8'h11);
    cyc(3'b100, 8'h04); cyc(3'b010, 8'h00);
    cyc(3'b100, 8'h10);
    idle_check("bank0_10", 8'h00);
    cyc(3'b100, 8'h08); cyc(3'b010, 8'h99);
    cyc(3'b100, 8'h04); cyc(3'b010, 8'h20);
    cyc(3'b100, 8'h08);
    idle_check("shared_08", 8'h99);
`endif

    // Random traffic with occasional mid-sequence reset
    for (int i = 0; i < 500; i++) begin
      logic       r;
      logic [2:0] cmd;
      r = ($urandom_range(0, 49) == 0);
      cmd = 3'($urandom);
      drive(r, cmd, 8'($urandom), 8'($urandom), 1'($urandom));
      if (r) check_value("rnd_rst_pcl", pclWriteEn, 1'b0);
      step();
    end

    // Reset after random traffic returns every state to its reset value
    drive(1'b1, 3'b111, 8'hAB, 8'hFF, 1'b1);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    check_value("end_rst_status", gprStatusOut, 8'h18);
    check_value("end_rst_addr", addrOut, 5'h00);
    check_value("end_rst_porta", portAOut, 8'h00);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
